// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types for the pipelined data memory.
// FSM state encoding, latency bounds and the response record.
package data_mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mem_st_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Widest data word the response record carries.
  localparam int DW_MAX = 64;

  typedef struct packed {
    logic              wr;
    logic              err;
    logic [DW_MAX-1:0] rdata;
  } rsp_rec_t;

endpackage

// File: rtl/mem_lat_pipe.sv
// mem_lat_pipe: LAT-deep response shift register, flushed by rst.
// Ports: clk, rst, in_valid/in_rec (accepted request), out_valid/out_rec.
module mem_lat_pipe
  import data_mem_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  rsp_rec_t in_rec,
  output logic     out_valid,
  output rsp_rec_t out_rec
);

  localparam int D = (LAT < LAT_MIN) ? LAT_MIN :
                     (LAT > LAT_MAX) ? LAT_MAX : LAT;

  logic [D-1:0] v;
  rsp_rec_t     r [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < D; i++) r[i] <= '0;
    end else begin
      v[0] <= in_valid;
      r[0] <= in_rec;
      for (int i = 1; i < D; i++) begin
        v[i] <= v[i-1];
        r[i] <= r[i-1];
      end
    end
  end

  assign out_valid = v[D-1];
  assign out_rec   = r[D-1];

endmodule

// File: rtl/data_mem_pipe.sv
// data_mem_pipe: single-port data memory, valid/ready, byte enables.
// Ports: clk, rst, req_* request channel, rsp_* response, init_busy.
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 65536,
  parameter int LAT        = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic                rsp_wr,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                init_busy
);

  localparam int BE_W = DATA_W / 8;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  mem_st_t           state, state_n;
  logic [IW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic          acc;
  logic          in_rng;
  logic [IW-1:0] idx;
  rsp_rec_t      in_rec, out_rec;
  logic          out_valid;
  logic          unused_rdata;

  // Gated by rst so ready stays low while reset is held.
  assign req_ready = (state == ST_RUN) && !rst;
  assign init_busy = (state == ST_INIT);
  assign acc       = req_valid && req_ready;
  // Range check uses all 32 address bits so high bits never alias.
  assign in_rng    = req_addr < 32'(DEPTH);
  assign idx       = IW'(req_addr[ADDR_W-1:0]);

  always_comb begin
    state_n = state;
    unique case (1'b1)
      (state == ST_INIT):
        if (INIT_CLEAR == 0 || cnt == LAST)
          state_n = ST_RUN;
      (state == ST_RUN):
        state_n = ST_RUN;
      default:
        state_n = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state == ST_INIT) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT && INIT_CLEAR != 0) begin
        mem[cnt] <= '0;
      end else if (acc && req_we && in_rng) begin
        for (int i = 0; i < BE_W; i++)
          if (req_be[i])
            mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  // Record is all-zero unless a request is accepted, keeping
  // rsp_rdata at 0 whenever rsp_valid is low.
  always_comb begin
    in_rec = '0;
    if (acc) begin
      in_rec.wr  = req_we;
      in_rec.err = !in_rng;
      if (!req_we && in_rng)
        in_rec.rdata = DW_MAX'(mem[idx]);
    end
  end

  mem_lat_pipe #(
    .LAT(LAT)
  ) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (acc),
    .in_rec   (in_rec),
    .out_valid(out_valid),
    .out_rec  (out_rec)
  );

  assign rsp_valid    = out_valid;
  assign rsp_wr       = out_rec.wr;
  assign rsp_err      = out_rec.err;
  assign rsp_rdata    = out_rec.rdata[DATA_W-1:0];
  assign unused_rdata = ^out_rec.rdata;

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb_data_mem_pipe: directed bench for data_mem_pipe.
// Four instances cover LAT 1/3/4 and INIT_CLEAR 0/1 at DEPTH=16.
module tb_data_mem_pipe;

  logic        clk = 1'b0;
  logic [3:0]  rst = 4'hF;
  logic [3:0]  req_valid = 4'h0;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;

  logic        req_ready [4];
  logic        rsp_valid [4];
  logic        rsp_wr    [4];
  logic        rsp_err   [4];
  logic [31:0] rsp_rdata [4];
  logic        init_busy [4];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    data_mem_pipe #(
      .DATA_W    (32),
      .ADDR_W    (16),
      .DEPTH     (16),
      .LAT       ((g == 1) ? 3 : (g == 2) ? 4 : 1),
      .INIT_CLEAR((g == 3) ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_we   (req_we),
      .req_be   (req_be),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[g]),
      .rsp_wr   (rsp_wr[g]),
      .rsp_err  (rsp_err[g]),
      .rsp_rdata(rsp_rdata[g]),
      .init_busy(init_busy[g])
    );
  end

  task automatic reset_dut(input int g, input int n);
    rst[g] = 1'b1;
    repeat (n) @(negedge clk);
    rst[g] = 1'b0;
  endtask

  task automatic drive(input int g, input logic we, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid[g] = 1'b1;
    req_we = we; req_be = be; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid[g] = 1'b0;
    req_we = 1'b0; req_be = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_init(input int g, output int n);
    n = 0;
    while (init_busy[g] && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_run++; if (req_ready[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", req_ready[0]); end
    n_run++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid[0]); end
    n_run++; if (rsp_wr[0] !== 1'b0) begin n_fail++; $display("FAIL reset_wr got=%b exp=0", rsp_wr[0]); end
    n_run++; if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", rsp_err[0]); end
    n_run++; if (rsp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata[0]); end
    n_run++; if (init_busy[0] !== 1'b1) begin n_fail++; $display("FAIL reset_busy got=%b exp=1", init_busy[0]); end
    rst[0] = 1'b0;
  endtask

  task automatic test_init();
    int n;
    bit bad;
    n = 0; bad = 1'b0;
    while (init_busy[0] && n < 100) begin
      if (req_ready[0] !== 1'b0) bad = 1'b1;
      n++;
      @(negedge clk);
    end
    n_run++; if (n != 16) begin n_fail++; $display("FAIL init_cycles got=%0d exp=16", n); end
    n_run++; if (bad) begin n_fail++; $display("FAIL init_ready_low got=1 exp=0"); end
    n_run++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL init_ready_rise got=%b exp=1", req_ready[0]); end
    drive(0, 1'b0, 4'h0, 32'd5, 32'h0);
    n_run++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL init_rd_valid got=%b exp=1", rsp_valid[0]); end
    n_run++; if (rsp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL init_rd_data got=%h exp=0", rsp_rdata[0]); end
    n_run++; if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL init_rd_err got=%b exp=0", rsp_err[0]); end
  endtask

  task automatic test_byte_en();
    drive(0, 1'b1, 4'b1111, 32'd3, 32'hAABBCCDD);
    n_run++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL be_wr_valid got=%b exp=1", rsp_valid[0]); end
    n_run++; if (rsp_wr[0] !== 1'b1) begin n_fail++; $display("FAIL be_wr_flag got=%b exp=1", rsp_wr[0]); end
    n_run++; if (rsp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL be_wr_rdata got=%h exp=0", rsp_rdata[0]); end
    drive(0, 1'b1, 4'b0101, 32'd3, 32'h11223344);
    drive(0, 1'b0, 4'b0000, 32'd3, 32'h0);
    n_run++; if (rsp_rdata[0] !== 32'hAA22CC44) begin n_fail++; $display("FAIL be_rd_data got=%h exp=aa22cc44", rsp_rdata[0]); end
    n_run++; if (rsp_wr[0] !== 1'b0) begin n_fail++; $display("FAIL be_rd_wr got=%b exp=0", rsp_wr[0]); end
    drive(0, 1'b1, 4'b0000, 32'd3, 32'hFFFFFFFF);
    n_run++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL be0_valid got=%b exp=1", rsp_valid[0]); end
    drive(0, 1'b0, 4'b0000, 32'd3, 32'h0);
    n_run++; if (rsp_rdata[0] !== 32'hAA22CC44) begin n_fail++; $display("FAIL be0_keep got=%h exp=aa22cc44", rsp_rdata[0]); end
  endtask

  task automatic test_error();
    drive(0, 1'b0, 4'h0, 32'd16, 32'h0);
    n_run++; if (rsp_valid[0] !== 1'b1) begin n_fail++; $display("FAIL err_rd_valid got=%b exp=1", rsp_valid[0]); end
    n_run++; if (rsp_err[0] !== 1'b1) begin n_fail++; $display("FAIL err_rd_err got=%b exp=1", rsp_err[0]); end
    n_run++; if (rsp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL err_rd_data got=%h exp=0", rsp_rdata[0]); end
    drive(0, 1'b1, 4'hF, 32'hFFFF0000, 32'hDEADBEEF);
    n_run++; if (rsp_err[0] !== 1'b1) begin n_fail++; $display("FAIL err_wr_err got=%b exp=1", rsp_err[0]); end
    n_run++; if (rsp_wr[0] !== 1'b1) begin n_fail++; $display("FAIL err_wr_wr got=%b exp=1", rsp_wr[0]); end
    n_run++; if (rsp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL err_wr_data got=%h exp=0", rsp_rdata[0]); end
    @(negedge clk);
    n_run++; if (rsp_valid[0] !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", rsp_valid[0]); end
    n_run++; if (rsp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL idle_rdata got=%h exp=0", rsp_rdata[0]); end
    drive(0, 1'b0, 4'h0, 32'd0, 32'h0);
    n_run++; if (rsp_rdata[0] !== 32'h0) begin n_fail++; $display("FAIL err_addr0 got=%h exp=0", rsp_rdata[0]); end
    n_run++; if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL err_addr0_err got=%b exp=0", rsp_err[0]); end
    drive(0, 1'b0, 4'h0, 32'd15, 32'h0);
    n_run++; if (rsp_err[0] !== 1'b0) begin n_fail++; $display("FAIL err_addr15 got=%b exp=0", rsp_err[0]); end
  endtask

  task automatic test_latency();
    logic        we_t [6];
    logic [31:0] ad_t [6];
    logic [31:0] wd_t [6];
    logic [31:0] exp_d;
    bit          exp_v;
    bit          exp_w;
    int          n;
    we_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ad_t = '{32'd0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2};
    wd_t = '{32'd55, 32'd31, 32'd1024, 32'd0, 32'd0, 32'd0};
    reset_dut(1, 2);
    wait_init(1, n);
    n_run++; if (n != 16) begin n_fail++; $display("FAIL lat_init got=%0d exp=16", n); end
    req_valid[1] = 1'b1; req_be = 4'hF;
    req_we = we_t[0]; req_addr = ad_t[0]; req_wdata = wd_t[0];
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j + 1 < 6) begin
        req_we = we_t[j+1]; req_addr = ad_t[j+1]; req_wdata = wd_t[j+1];
      end else begin
        req_valid[1] = 1'b0; req_we = 1'b0; req_be = '0;
      end
      exp_v = (j >= 2 && j <= 7);
      exp_w = (j >= 2 && j <= 4);
      exp_d = (j >= 5 && j <= 7) ? wd_t[j-5] : 32'h0;
      n_run++; if (rsp_valid[1] !== exp_v) begin n_fail++; $display("FAIL lat_valid[%0d] got=%b exp=%b", j, rsp_valid[1], exp_v); end
      if (exp_v) begin
        n_run++; if (rsp_wr[1] !== exp_w) begin n_fail++; $display("FAIL lat_wr[%0d] got=%b exp=%b", j, rsp_wr[1], exp_w); end
      end
      n_run++; if (rsp_rdata[1] !== exp_d) begin n_fail++; $display("FAIL lat_data[%0d] got=%0d exp=%0d", j, rsp_rdata[1], exp_d); end
    end
  endtask

  task automatic test_reset_midflight();
    int n;
    int nv;
    reset_dut(2, 2);
    wait_init(2, n);
    drive(2, 1'b1, 4'hF, 32'd9, 32'h12345678);
    repeat (3) @(negedge clk);
    drive(2, 1'b0, 4'h0, 32'd9, 32'h0);
    repeat (3) @(negedge clk);
    n_run++; if (rsp_rdata[2] !== 32'h12345678) begin n_fail++; $display("FAIL mid_pre got=%h exp=12345678", rsp_rdata[2]); end
    req_valid[2] = 1'b1; req_we = 1'b0; req_addr = 32'd9;
    @(negedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0; req_addr = '0;
    reset_dut(2, 1);
    n = 0; nv = 0;
    while (init_busy[2] && n < 100) begin
      if (rsp_valid[2] !== 1'b0) nv++;
      n++;
      @(negedge clk);
    end
    repeat (4) begin
      if (rsp_valid[2] !== 1'b0) nv++;
      @(negedge clk);
    end
    n_run++; if (nv != 0) begin n_fail++; $display("FAIL mid_flush got=%0d exp=0", nv); end
    n_run++; if (n != 16) begin n_fail++; $display("FAIL mid_init got=%0d exp=16", n); end
    drive(2, 1'b0, 4'h0, 32'd9, 32'h0);
    repeat (3) @(negedge clk);
    n_run++; if (rsp_valid[2] !== 1'b1) begin n_fail++; $display("FAIL mid_rd_valid got=%b exp=1", rsp_valid[2]); end
    n_run++; if (rsp_rdata[2] !== 32'h0) begin n_fail++; $display("FAIL mid_cleared got=%h exp=0", rsp_rdata[2]); end
  endtask

  task automatic test_no_clear();
    n_run++; if (req_ready[3] !== 1'b0) begin n_fail++; $display("FAIL nc_rst_ready got=%b exp=0", req_ready[3]); end
    n_run++; if (init_busy[3] !== 1'b0) begin n_fail++; $display("FAIL nc_busy got=%b exp=0", init_busy[3]); end
    rst[3] = 1'b0;
    #1;
    n_run++; if (req_ready[3] !== 1'b1) begin n_fail++; $display("FAIL nc_ready got=%b exp=1", req_ready[3]); end
    @(negedge clk);
    drive(3, 1'b1, 4'hF, 32'd7, 32'd9);
    n_run++; if (rsp_wr[3] !== 1'b1) begin n_fail++; $display("FAIL nc_wr got=%b exp=1", rsp_wr[3]); end
    rst[3] = 1'b1;
    @(negedge clk);
    #1;
    n_run++; if (req_ready[3] !== 1'b0) begin n_fail++; $display("FAIL nc_rst_ready2 got=%b exp=0", req_ready[3]); end
    @(negedge clk);
    rst[3] = 1'b0;
    #1;
    n_run++; if (req_ready[3] !== 1'b1) begin n_fail++; $display("FAIL nc_ready2 got=%b exp=1", req_ready[3]); end
    @(negedge clk);
    drive(3, 1'b0, 4'h0, 32'd7, 32'h0);
    n_run++; if (rsp_valid[3] !== 1'b1) begin n_fail++; $display("FAIL nc_rd_valid got=%b exp=1", rsp_valid[3]); end
    n_run++; if (rsp_rdata[3] !== 32'd9) begin n_fail++; $display("FAIL nc_rd_data got=%0d exp=9", rsp_rdata[3]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_init();
    test_byte_en();
    test_error();
    test_latency();
    test_reset_midflight();
    test_no_clear();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
- Parametrised single-port data memory, successor to the fixed 65536x32 data memory.
- Adds a valid/ready request channel, byte-lane write enables and a configurable read latency pipeline.
- Adds a per-request response with an out-of-range error flag, and a synchronous reset that optionally zero-fills the array via an init state machine.
- Sits between the MEM pipeline stage and the memory array; every accepted request returns exactly one response.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width; bits of req_addr above ADDR_W are ignored for indexing.
- DEPTH, 65536, number of words implemented; must be <= 2**ADDR_W.
- LAT, 1, cycles from request acceptance to response; legal range 1..4.
- INIT_CLEAR, 1, 1 = zero-fill all DEPTH words after reset; 0 = array contents untouched by reset.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_be  in  DATA_W/8  byte-lane write enables; ignored for reads.
- req_addr  in  32  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response valid; pulses for one cycle per accepted request.
- rsp_wr  out  1  response belongs to a write.
- rsp_err  out  1  request address was >= DEPTH.
- rsp_rdata  out  DATA_W  read data; zero on writes and on errors.
- init_busy  out  1  high while zero-fill is in progress.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named rst.
- Reset values: req_ready=0, rsp_valid=0, rsp_wr=0, rsp_err=0, rsp_rdata=0. init_busy=1 if INIT_CLEAR, else 0. Latency pipeline flushed.
- Reset mid-operation: all in-flight responses are discarded (no rsp_valid for them), and the FSM restarts from INIT or RUN.
- FSM states: INIT, RUN.
  - INIT (INIT_CLEAR=1 only): an init counter steps 0..DEPTH-1, writing 0 to one word per cycle. req_ready=0 throughout.
  - On the cycle that writes word DEPTH-1, the next state is RUN and init_busy falls. INIT takes exactly DEPTH cycles after rst deasserts.
  - With INIT_CLEAR=0, the FSM enters RUN on the first cycle after rst deasserts.
- In RUN, req_ready=1 every cycle. There is no back-pressure from the response side.
- Accept rule: a request is accepted on a posedge where req_valid && req_ready. At most one request per cycle.
- Write: each byte lane i with req_be[i]=1 updates bits [8i+7:8i]; the other lanes keep their value.
  - be=0 is legal; it writes nothing but still produces a response.
- Read: returns the array word as of the accepting edge. A write accepted on an earlier edge is visible; there is no same-cycle ambiguity because the port is single-access.
- Out of range (req_addr >= DEPTH, evaluated on the full 32 bits): no array access; the response has rsp_err=1 and rsp_rdata=0.
- Response timing: a request accepted at edge N gives rsp_valid=1 in the cycle after edge N+LAT-1, i.e. LAT cycles of latency.
  - rsp_wr, rsp_err and rsp_rdata are valid only when rsp_valid=1.
  - When rsp_valid=0, rsp_rdata holds 0.
- Throughput: back-to-back requests give back-to-back responses, in order. The pipeline holds up to LAT outstanding requests.
- Array storage: no reset other than the INIT fill. A read of an untouched word with INIT_CLEAR=0 returns simulator X; the bench must not rely on its value.

Decomposition:
- Shared package data_mem_pkg:
  - FSM state encoding: ST_INIT=1'b0, ST_RUN=1'b1.
  - Latency bounds: LAT_MIN=1, LAT_MAX=4.
  - A response-record struct {wr, err, rdata} used by the latency pipeline.
- One sub-module, mem_lat_pipe: a LAT-deep shift register of {valid, wr, err, rdata} with synchronous flush on rst.
- Array, byte-lane write and FSM stay in data_mem_pipe.

Test Plan:
- Init: DEPTH=16, INIT_CLEAR=1, pulse rst for 2 cycles -> init_busy high exactly 16 cycles, req_ready rises on cycle 17, a read of addr 5 returns 0.
- Byte enables: write addr 3 = 0xAABBCCDD with be=4'b1111, then write 0x11223344 with be=4'b0101, then read addr 3 -> rsp_rdata=0xAA22CC44, rsp_wr=0.
- Latency: LAT=3, reads of addrs 0,1,2 issued on consecutive cycles after writes of 55,31,1024 -> rsp_valid on 3 consecutive cycles starting 3 cycles after the first accept, with data 55,31,1024 in order.
- Error: DEPTH=16, read addr 16 and write addr 0xFFFF0000 -> both responses have rsp_err=1 and rsp_rdata=0; a later read of addr 0 is unchanged.
- Reset mid-flight: LAT=4, issue 2 reads, assert rst on the next cycle -> no rsp_valid for those reads, init restarts, and the previously written word reads back 0 after init.
- No clear: INIT_CLEAR=0, write addr 7 = 9, pulse rst, read addr 7 -> req_ready=1 on the first cycle after rst, rsp_rdata=9.
